// File: rtl/graph_pkg.sv
// Encodings shared by the trace sequencer and the pixel renderer's colour logic.
package graph_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_LOW   = 2'b00,
    S_HIGH  = 2'b01,
    S_UNDEF = 2'b10,
    S_HIZ   = 2'b11
  } sample_e;

endpackage

// File: rtl/trace_bank.sv
// Double-buffered sample store: capture writes the back bank, display reads the front bank.
module trace_bank
  import graph_pkg::*;
#(
  parameter int unsigned CELLS = 32,
  parameter int unsigned CW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [CW-1:0] waddr_i,
  input  logic [1:0]    wdata_i,
  input  logic          swap_i,
  input  logic [CW-1:0] rcol_i,
  output logic [1:0]    rdata_o,
  output logic [1:0]    rprev_o
);

  logic [1:0]    bank0_q [CELLS];
  logic [1:0]    bank1_q [CELLS];
  logic          sel_q;
  logic [CW-1:0] pcol;

  // sel_q names the front bank; the other one is always the write target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 1'b0;
      bank0_q <= '{default: S_LOW};
      bank1_q <= '{default: S_LOW};
    end else begin
      if (we_i && sel_q)  bank0_q[waddr_i] <= wdata_i;
      if (we_i && !sel_q) bank1_q[waddr_i] <= wdata_i;
      if (swap_i)         sel_q <= ~sel_q;
    end
  end

  assign pcol    = rcol_i - CW'(1);
  assign rdata_o = sel_q ? bank1_q[rcol_i] : bank0_q[rcol_i];
  assign rprev_o = sel_q ? bank1_q[pcol]   : bank0_q[pcol];

endmodule

// File: rtl/trace_ctrl.sv
// Capture-and-display sequencer for one logic-monitor channel: trigger/capture FSM,
// bank swap at frame start, and pixel-to-cell scan feeding the trace renderer.
module trace_ctrl
  import graph_pkg::*;
#(
  parameter int unsigned CELLS = 32,
  parameter int unsigned CW    = 5,
  parameter logic [10:0] PX    = 11'd10,
  parameter logic [10:0] BX    = 11'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [1:0]  sample,
  input  logic        arm,
  input  logic        frame_start,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  output logic [10:0] x_d,
  output logic [9:0]  y_d,
  output logic [1:0]  state,
  output logic        change,
  output logic        in_trace,
  output logic [1:0]  status
);

  status_e       fsm_q;
  logic [CW-1:0] wr_ptr_q;
  logic [1:0]    prev_q;
  logic          trigger;

  logic          we;
  logic [CW-1:0] waddr;
  logic          swap;
  logic [1:0]    rdata;
  logic [1:0]    rprev;

  logic [CW-1:0] col_q, col_d;
  logic [10:0]   sub_q, sub_d;
  logic          active_q, active_d;
  logic [10:0]   x_d_q;
  logic [9:0]    y_d_q;
  logic [1:0]    state_q;
  logic          change_q;
  logic          in_trace_q;

  assign trigger = sample_en && (sample == S_HIGH) && (prev_q == S_LOW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q    <= ST_IDLE;
      wr_ptr_q <= '0;
      prev_q   <= S_LOW;
    end else begin
      if (sample_en) prev_q <= sample;
      unique case (fsm_q)
        ST_IDLE: if (arm) fsm_q <= ST_ARMED;
        ST_ARMED: if (trigger) begin
          fsm_q    <= ST_CAPTURE;
          wr_ptr_q <= CW'(1);
        end
        ST_CAPTURE: begin
          if (arm) begin
            fsm_q    <= ST_ARMED;
            wr_ptr_q <= '0;
          end else if (sample_en) begin
            wr_ptr_q <= wr_ptr_q + CW'(1);
            if (wr_ptr_q == CW'(CELLS - 1)) fsm_q <= ST_DONE;
          end
        end
        ST_DONE: if (frame_start) fsm_q <= ST_IDLE;
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  // A restart request in CAPTURE takes precedence over a coincident sample.
  assign we    = (fsm_q == ST_ARMED && trigger) ||
                 (fsm_q == ST_CAPTURE && sample_en && !arm);
  assign waddr = (fsm_q == ST_ARMED) ? '0 : wr_ptr_q;
  assign swap  = (fsm_q == ST_DONE) && frame_start;

  trace_bank #(
    .CELLS(CELLS),
    .CW   (CW)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(sample),
    .swap_i (swap),
    .rcol_i (col_d),
    .rdata_o(rdata),
    .rprev_o(rprev)
  );

  // x_d_q is also the previous x, which exposes a line wrap while active.
  always_comb begin
    col_d    = col_q;
    sub_d    = sub_q;
    active_d = active_q;
    if (x == PX) begin
      col_d    = '0;
      sub_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (x < x_d_q) begin
        active_d = 1'b0;
      end else if (sub_q == BX - 11'd1) begin
        sub_d = '0;
        col_d = col_q + CW'(1);
        if (col_q == CW'(CELLS - 1)) active_d = 1'b0;
      end else begin
        sub_d = sub_q + 11'd1;
      end
    end
  end

  // Pixel outputs come from the next-state counters so they align with x_d.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q      <= '0;
      sub_q      <= '0;
      active_q   <= 1'b0;
      x_d_q      <= '0;
      y_d_q      <= '0;
      state_q    <= S_LOW;
      change_q   <= 1'b0;
      in_trace_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      sub_q      <= sub_d;
      active_q   <= active_d;
      x_d_q      <= x;
      y_d_q      <= y;
      in_trace_q <= active_d;
      state_q    <= active_d ? rdata : S_LOW;
      change_q   <= active_d && (sub_d == '0) && (col_d != '0) && (rdata != rprev);
    end
  end

  assign x_d      = x_d_q;
  assign y_d      = y_d_q;
  assign state    = state_q;
  assign change   = change_q;
  assign in_trace = in_trace_q;
  assign status   = fsm_q;

endmodule

// File: tb/tb_trace_ctrl.sv
// Self-checking bench for trace_ctrl: capture sequencing, bank swap timing and scan geometry.
module tb_trace_ctrl;

  localparam int NC  = 32;
  localparam int PXI = 10;
  localparam int BXI = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic [1:0]  sample = 2'b00;
  logic        arm = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic [10:0] x_d;
  logic [9:0]  y_d;
  logic [1:0]  state;
  logic        change;
  logic        in_trace;
  logic [1:0]  status;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_front [NC];
  logic [1:0] capt [NC];

  typedef struct packed {
    logic [10:0] xd;
    logic [9:0]  yd;
    logic        it;
    logic [1:0]  st;
    logic        ch;
  } pix_t;

  pix_t sb[$];

  always #5 clk = ~clk;

  trace_ctrl #(
    .CELLS(32),
    .CW   (5),
    .PX   (11'd10),
    .BX   (11'd10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .sample     (sample),
    .arm        (arm),
    .frame_start(frame_start),
    .x          (x),
    .y          (y),
    .x_d        (x_d),
    .y_d        (y_d),
    .state      (state),
    .change     (change),
    .in_trace   (in_trace),
    .status     (status)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s);
    sample_en = 1'b1;
    sample    = s;
    tick();
    sample_en = 1'b0;
    sample    = 2'b00;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Drives x across [x0,x1]; expected pixels are queued as x is driven and
  // popped one clk later when the registered outputs appear.
  task automatic scan(input int x0, input int x1, input bit live, input int yy);
    pix_t e, got, w;
    int c, s;
    for (int xx = x0; xx <= x1; xx++) begin
      e.xd = 11'(xx);
      e.yd = 10'(yy);
      e.it = 1'b0;
      e.st = 2'b00;
      e.ch = 1'b0;
      if (live && xx >= PXI && xx < PXI + NC * BXI) begin
        c = (xx - PXI) / BXI;
        s = (xx - PXI) % BXI;
        e.it = 1'b1;
        e.st = exp_front[c];
        if (s == 0 && c != 0) e.ch = (exp_front[c] != exp_front[c-1]);
      end
      sb.push_back(e);
      x = 11'(xx);
      y = 10'(yy);
      tick();
      got = {x_d, y_d, in_trace, state, change};
      w = sb.pop_front();
      checks++;
      if (got !== w) begin
        errors++;
        $display("FAIL scan x=%0d y=%0d: got xd=%0d yd=%0d it=%b st=%b ch=%b, want xd=%0d yd=%0d it=%b st=%b ch=%b",
                 xx, yy, got.xd, got.yd, got.it, got.st, got.ch, w.xd, w.yd, w.it, w.st, w.ch);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if (status   !== 2'b00) begin errors++; $display("FAIL rst_status: got %b want 00", status); end
    checks++; if (in_trace !== 1'b0)  begin errors++; $display("FAIL rst_in_trace: got %b want 0", in_trace); end
    checks++; if (state    !== 2'b00) begin errors++; $display("FAIL rst_state: got %b want 00", state); end
    checks++; if (change   !== 1'b0)  begin errors++; $display("FAIL rst_change: got %b want 0", change); end
    checks++; if (x_d      !== 11'd0) begin errors++; $display("FAIL rst_x_d: got %0d want 0", x_d); end
    checks++; if (y_d      !== 10'd0) begin errors++; $display("FAIL rst_y_d: got %0d want 0", y_d); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    scan(0, 639, 1'b1, 1);
  endtask

  task automatic test_capture();
    pulse_arm();
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL cap_armed: got %b want 01", status); end
    send(2'b00);
    send(2'b00);
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL cap_no_trig: got %b want 01", status); end
    send(2'b01);
    capt[0] = 2'b01;
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL cap_trig: got %b want 10", status); end
    for (int k = 1; k < NC; k++) begin
      capt[k] = (k % 2 == 0) ? 2'b01 : 2'b00;
      send(capt[k]);
      if (k == NC - 2) begin
        checks++; if (status !== 2'b10) begin errors++; $display("FAIL cap_penult: got %b want 10", status); end
      end
    end
    checks++; if (status !== 2'b11) begin errors++; $display("FAIL cap_done: got %b want 11", status); end
    tick(); tick(); tick();
    checks++; if (status !== 2'b11) begin errors++; $display("FAIL cap_done_hold: got %b want 11", status); end
    pulse_frame();
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL cap_idle: got %b want 00", status); end
    for (int k = 0; k < NC; k++) exp_front[k] = capt[k];
    scan(0, 639, 1'b1, 2);
  endtask

  task automatic test_notear();
    pulse_arm();
    send(2'b00);
    send(2'b01);
    capt[0] = 2'b01;
    for (int k = 1; k < 12; k++) begin capt[k] = 2'b11; send(2'b11); end
    pulse_frame();
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL tear_status: got %b want 10", status); end
    scan(0, 639, 1'b1, 3);
    for (int k = 12; k < NC; k++) begin capt[k] = 2'b11; send(2'b11); end
    checks++; if (status !== 2'b11) begin errors++; $display("FAIL tear_done: got %b want 11", status); end
    pulse_arm();
    checks++; if (status !== 2'b11) begin errors++; $display("FAIL done_arm_ignored: got %b want 11", status); end
    pulse_frame();
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL tear_swap_idle: got %b want 00", status); end
    for (int k = 0; k < NC; k++) exp_front[k] = capt[k];
    scan(0, 639, 1'b1, 4);
  endtask

  task automatic test_rearm();
    pulse_arm();
    send(2'b00);
    send(2'b01);
    for (int k = 1; k < 20; k++) send(2'b10);
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL rearm_capture: got %b want 10", status); end
    pulse_arm();
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL rearm_armed: got %b want 01", status); end
    send(2'b01);
    send(2'b01);
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL rearm_no_edge: got %b want 01", status); end
    send(2'b00);
    send(2'b01);
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL rearm_trig: got %b want 10", status); end
    capt[0] = 2'b01;
    for (int k = 1; k < NC; k++) begin capt[k] = 2'(k % 4); send(capt[k]); end
    checks++; if (status !== 2'b11) begin errors++; $display("FAIL rearm_done: got %b want 11", status); end
    pulse_frame();
    for (int k = 0; k < NC; k++) exp_front[k] = capt[k];
    scan(0, 639, 1'b1, 5);
  endtask

  task automatic test_simul();
    pulse_arm();
    send(2'b00);
    sample_en   = 1'b1;
    sample      = 2'b01;
    frame_start = 1'b1;
    tick();
    sample_en   = 1'b0;
    sample      = 2'b00;
    frame_start = 1'b0;
    capt[0] = 2'b01;
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL simul_status: got %b want 10", status); end
    scan(0, 639, 1'b1, 6);
    for (int k = 1; k < NC; k++) begin capt[k] = 2'b00; send(2'b00); end
    checks++; if (status !== 2'b11) begin errors++; $display("FAIL simul_done: got %b want 11", status); end
    pulse_frame();
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL simul_idle: got %b want 00", status); end
    for (int k = 0; k < NC; k++) exp_front[k] = capt[k];
    scan(0, 639, 1'b1, 7);
  endtask

  task automatic test_scan_wrap();
    scan(0, 100, 1'b1, 8);
    scan(60, 200, 1'b0, 8);
    scan(0, 639, 1'b1, 9);
  endtask

  task automatic test_reset_mid();
    pulse_arm();
    send(2'b00);
    send(2'b01);
    for (int k = 1; k < 7; k++) send(2'b01);
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL mid_capture: got %b want 10", status); end
    scan(0, 50, 1'b1, 10);
    #2 rst = 1'b0;
    #1;
    checks++; if (status   !== 2'b00) begin errors++; $display("FAIL mid_rst_status: got %b want 00", status); end
    checks++; if (in_trace !== 1'b0)  begin errors++; $display("FAIL mid_rst_in_trace: got %b want 0", in_trace); end
    checks++; if (state    !== 2'b00) begin errors++; $display("FAIL mid_rst_state: got %b want 00", state); end
    checks++; if (change   !== 1'b0)  begin errors++; $display("FAIL mid_rst_change: got %b want 0", change); end
    checks++; if (x_d      !== 11'd0) begin errors++; $display("FAIL mid_rst_x_d: got %0d want 0", x_d); end
    tick();
    rst = 1'b1;
    x   = '0;
    tick();
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL mid_post_status: got %b want 00", status); end
    for (int k = 0; k < NC; k++) exp_front[k] = 2'b00;
    scan(0, 639, 1'b1, 11);
  endtask

  initial begin
    for (int k = 0; k < NC; k++) begin
      exp_front[k] = 2'b00;
      capt[k]      = 2'b00;
    end
    test_reset();
    test_capture();
    test_notear();
    test_rearm();
    test_simul();
    test_scan_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
